spi_slave_shifter: RTL and testbench



---
 rtl/spi_pkg.sv | 8 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave_shifter.sv | 146 ++++++++++++++
 tb/tb_spi_slave_shifter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 slave front end.
package spi_pkg;

    typedef enum logic {IDLE, SHIFT} spi_state_t;

    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with a trailing flop for edge detection.
module spi_sync_edge
    import spi_pkg::*;
(
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        level_o = sync_q[SYNC_STAGES-1];
        rise_o  = level_o & ~prev_q;
        fall_o  = ~level_o & prev_q;
    end

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave: oversamples SCLK/MOSI/CS_N on clk, deserialises N-bit words onto data/load
// and serialises tx_data onto MISO within the same frame.
module spi_slave_shifter
    import spi_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sclk,
    input  logic         mosi,
    input  logic         cs_n,
    input  logic [N-1:0] tx_data,
    output logic         miso,
    output logic [N-1:0] data,
    output logic         load,
    output logic         busy,
    output logic         frame_err
);

    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] LastCnt = CW'(N - 1);

    logic sclk_rise, sclk_fall, sclk_level_unused;
    logic cs_start, cs_end, cs_level_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge u_sync_sclk (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (sclk),
        .level_o (sclk_level_unused),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    // cs_n is active low: its falling edge starts a frame, its rising edge ends one.
    spi_sync_edge u_sync_cs (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (cs_n),
        .level_o (cs_level_unused),
        .rise_o  (cs_end),
        .fall_o  (cs_start)
    );

    spi_sync_edge u_sync_mosi (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (mosi),
        .level_o (mosi_s),
        .rise_o  (mosi_rise_unused),
        .fall_o  (mosi_fall_unused)
    );

    spi_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  rx_q, rx_d, rx_next;
    logic [N-1:0]  tx_q, tx_d, tx_shifted;
    logic [N-1:0]  data_q, data_d;
    logic          load_q, load_d;
    logic          err_q, err_d;
    logic          reload_q, reload_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        data_d     = data_q;
        reload_d   = reload_q;
        load_d     = 1'b0;
        err_d      = 1'b0;
        rx_next    = MSB_FIRST ? {rx_q[N-2:0], mosi_s} : {mosi_s, rx_q[N-1:1]};
        tx_shifted = MSB_FIRST ? {tx_q[N-2:0], 1'b0} : {1'b0, tx_q[N-1:1]};

        unique case (state_q)
            IDLE: begin
                if (cs_start) begin
                    state_d  = SHIFT;
                    tx_d     = tx_data;
                    cnt_d    = '0;
                    rx_d     = '0;
                    reload_d = 1'b0;
                end
            end
            SHIFT: begin
                // cs_end takes priority over any SCLK edge seen in the same cycle.
                if (cs_end) begin
                    state_d = IDLE;
                    err_d   = (cnt_q != '0);
                end else begin
                    if (sclk_rise) begin
                        rx_d = rx_next;
                        if (cnt_q == LastCnt) begin
                            cnt_d    = '0;
                            data_d   = rx_next;
                            load_d   = 1'b1;
                            reload_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    // The fall after a completed word fetches the next transmit word.
                    if (sclk_fall) begin
                        reload_d = 1'b0;
                        tx_d     = reload_q ? tx_data : tx_shifted;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rx_q     <= '0;
            tx_q     <= '0;
            data_q   <= '0;
            load_q   <= 1'b0;
            err_q    <= 1'b0;
            reload_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rx_q     <= rx_d;
            tx_q     <= tx_d;
            data_q   <= data_d;
            load_q   <= load_d;
            err_q    <= err_d;
            reload_q <= reload_d;
        end
    end

    always_comb begin
        busy      = (state_q == SHIFT);
        miso      = busy ? (MSB_FIRST ? tx_q[N-1] : tx_q[0]) : 1'b0;
        data      = data_q;
        load      = load_q;
        frame_err = err_q;
    end

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Scoreboard bench: an MSB-first and an LSB-first instance share the SPI pins; expected words
// are derived from the transmitted bit stream and checked by a monitor when load/frame_err fire.
module tb_spi_slave_shifter;

    logic       clk = 1'b0;
    logic       reset, sclk, mosi, cs_n;
    logic [7:0] tx_data;
    logic       miso0, miso1, load0, load1, busy0, busy1, err0, err1;
    logic [7:0] data0, data1;

    always #5 clk = ~clk;

    spi_slave_shifter #(.N(8), .MSB_FIRST(1'b1)) u_msb (
        .clk       (clk),
        .reset     (reset),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs_n      (cs_n),
        .tx_data   (tx_data),
        .miso      (miso0),
        .data      (data0),
        .load      (load0),
        .busy      (busy0),
        .frame_err (err0)
    );

    spi_slave_shifter #(.N(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk       (clk),
        .reset     (reset),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs_n      (cs_n),
        .tx_data   (tx_data),
        .miso      (miso1),
        .data      (data1),
        .load      (load1),
        .busy      (busy1),
        .frame_err (err1)
    );

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int         err_exp0 = 0;
    int         err_exp1 = 0;
    logic [7:0] last0 = 8'h00;
    logic [7:0] last1 = 8'h00;
    logic       load0_prev = 1'b0;
    logic       load1_prev = 1'b0;
    logic       bits_q[$];
    logic [7:0] tx_plan[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: word k of the stream, first-sent bit landing at the MSB or the LSB.
    function automatic logic [7:0] word_of(input int base, input bit msb_first);
        logic [7:0] w;
        for (int j = 0; j < 8; j++) begin
            if (msb_first) w[7-j] = bits_q[base+j];
            else           w[j]   = bits_q[base+j];
        end
        return w;
    endfunction

    task automatic push_word(input logic [7:0] w);
        for (int j = 7; j >= 0; j--) bits_q.push_back(w[j]);
    endtask

    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (load0) begin
                check("load msb expected", 32'(exp_q0.size() != 0), 1);
                check("load msb width", load0_prev, 0);
                if (exp_q0.size() != 0) begin
                    e = exp_q0.pop_front();
                    check("data msb", data0, e);
                    last0 = e;
                end
            end
            if (load1) begin
                check("load lsb expected", 32'(exp_q1.size() != 0), 1);
                check("load lsb width", load1_prev, 0);
                if (exp_q1.size() != 0) begin
                    e = exp_q1.pop_front();
                    check("data lsb", data1, e);
                    last1 = e;
                end
            end
            if (err0) begin
                check("frame_err msb expected", 32'(err_exp0 > 0), 1);
                if (err_exp0 > 0) err_exp0--;
            end
            if (err1) begin
                check("frame_err lsb expected", 32'(err_exp1 > 0), 1);
                if (err_exp1 > 0) err_exp1--;
            end
            load0_prev = load0;
            load1_prev = load1;
        end
    endtask

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    // Plays bits_q as one frame; tx_plan[k] is the word expected on MISO for word k.
    task automatic run_frame();
        int         nbits;
        int         w;
        logic [7:0] got0, got1;
        nbits = bits_q.size();
        got0  = '0;
        got1  = '0;
        tx_data = tx_plan[0];
        @(negedge clk);
        cs_n = 1'b0;
        repeat (2) @(negedge clk);
        check("busy before sync", busy0, 0);
        @(negedge clk);
        check("busy msb after 3 clk", busy0, 1);
        check("busy lsb after 3 clk", busy1, 1);
        repeat (5) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            w    = i / 8;
            mosi = bits_q[i];
            half();
            got0[7-(i%8)] = miso0;
            got1[i%8]     = miso1;
            sclk = 1'b1;
            if (i % 8 == 7) begin
                exp_q0.push_back(word_of(w * 8, 1'b1));
                exp_q1.push_back(word_of(w * 8, 1'b0));
                check("miso msb word", got0, tx_plan[w]);
                check("miso lsb word", got1, tx_plan[w]);
            end
            if (i % 8 == 3 && w + 1 < tx_plan.size()) tx_data = tx_plan[w+1];
            half();
            sclk = 1'b0;
        end
        if (nbits % 8 != 0) begin
            err_exp0++;
            err_exp1++;
        end
        half();
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        check("miso idle", {miso1, miso0}, 0);
        check("busy idle", {busy1, busy0}, 0);
        if (nbits % 8 != 0) begin
            check("data kept msb", data0, last0);
            check("data kept lsb", data1, last1);
        end
        bits_q.delete();
        tx_plan.delete();
    endtask

    initial begin
        int nw, extra;
        reset   = 1'b1;
        sclk    = 1'b0;
        mosi    = 1'b0;
        cs_n    = 1'b1;
        tx_data = 8'h00;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        check("reset data", {data1, data0}, 0);
        check("reset load/busy/err", {load1, load0, busy1, busy0, err1, err0}, 0);
        check("reset miso", {miso1, miso0}, 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        push_word(8'hA5);
        tx_plan = '{8'h3C, 8'h00};
        run_frame();

        push_word(8'h12);
        push_word(8'hF0);
        tx_plan = '{8'h3C, 8'h81, 8'h00};
        run_frame();

        for (int i = 0; i < 5; i++) bits_q.push_back(1'($urandom_range(0, 1)));
        tx_plan = '{8'h55, 8'h00};
        run_frame();

        push_word(8'h80);
        tx_plan = '{8'h01, 8'h00};
        run_frame();

        // Abandon a frame with reset after four SCLK rises.
        tx_data = 8'hFF;
        cs_n = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            mosi = 1'b1;
            half();
            sclk = 1'b1;
            half();
            sclk = 1'b0;
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("mid reset data", {data1, data0}, 0);
        check("mid reset load/busy/err", {load1, load0, busy1, busy0, err1, err0}, 0);
        check("mid reset miso", {miso1, miso0}, 0);
        last0 = 8'h00;
        last1 = 8'h00;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);

        push_word(8'hC3);
        tx_plan = '{8'h5A, 8'h00};
        run_frame();

        for (int f = 0; f < 8; f++) begin
            nw    = $urandom_range(1, 3);
            extra = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7);
            for (int i = 0; i < nw * 8 + extra; i++) bits_q.push_back(1'($urandom_range(0, 1)));
            for (int k = 0; k <= nw; k++) tx_plan.push_back(8'($urandom));
            run_frame();
        end

        repeat (20) @(negedge clk);
        check("unconsumed loads msb", exp_q0.size(), 0);
        check("unconsumed loads lsb", exp_q1.size(), 0);
        check("missing frame_err", err_exp0 + err_exp1, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
